// File: rtl/sanduba_pkg.sv
// Shared definitions for the sandwich vending front panel and its controller.
// Channel order matches the bit order of the panel's pending vector.
package sanduba_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2
  } panel_state_t;

  localparam int NUM_CH   = 5;
  localparam int CH_M100  = 0;
  localparam int CH_DEV   = 1;
  localparam int CH_GREEN = 2;
  localparam int CH_ATUM  = 3;
  localparam int CH_BACON = 4;

  // Sandwich prices in units of the 100-coin accepted by the coin sensor.
  localparam int COST_GREEN = 3;
  localparam int COST_ATUM  = 4;
  localparam int COST_BACON = 5;

  // One request class per issue: refund alone, then coin alone, then every
  // pending sandwich together so the controller can reject a multi-select.
  function automatic logic [NUM_CH-1:0] select_issue(input logic [NUM_CH-1:0] req);
    logic [NUM_CH-1:0] sel;
    sel = '0;
    if (req[CH_DEV]) begin
      sel[CH_DEV] = 1'b1;
    end else if (req[CH_M100]) begin
      sel[CH_M100] = 1'b1;
    end else begin
      sel = req;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sanduba_debounce.sv
// One panel input: two-flop synchronizer followed by a counting debouncer.
// o_press is high on the edge where the stable level is about to rise.
module sanduba_debounce #(
  parameter  int DEB_CYCLES = 4,
  localparam int CW         = $clog2(DEB_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_press
);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_mismatch;
  logic          w_accept;

  assign w_mismatch = r_sync2 ^ r_stable;
  assign w_accept   = w_mismatch && (r_cnt == CW'(DEB_CYCLES - 1));
  assign o_press    = w_accept && r_sync2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value; the
      // synchronizer chain only works if r_sync2 takes the old r_sync1.
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_mismatch || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_stable <= r_sync2;
      end
    end
  end

endmodule

// File: rtl/sanduba_panel.sv
// Front-panel conditioner: debounces five inputs, holds presses pending while
// the controller is busy and issues them as one-cycle pulses, one class at a time.
module sanduba_panel
  import sanduba_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_m100,
  input  logic       raw_dev,
  input  logic       raw_green,
  input  logic       raw_atum,
  input  logic       raw_bacon,
  input  logic       busy,
  output logic       m100,
  output logic       dev,
  output logic       r_green,
  output logic       r_atum,
  output logic       r_bacon,
  output logic       drop,
  output logic [4:0] pend
);

  panel_state_t      r_state;
  panel_state_t      w_next_state;
  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_press;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_issue;
  logic              r_drop;

  assign w_raw = {raw_bacon, raw_atum, raw_green, raw_dev, raw_m100};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sanduba_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock  (clock),
      .reset  (reset),
      .i_raw  (w_raw[g]),
      .o_press(w_press[g])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves the value held,
    // which would otherwise infer a latch.
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!busy && (r_pend != '0)) w_next_state = ISSUE;
      ISSUE:   w_next_state = GUARD;
      GUARD:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // busy only matters in IDLE; the GUARD cycle lets the controller raise it.
  always_comb begin
    w_sel = '0;
    if ((r_state == IDLE) && !busy && (r_pend != '0)) begin
      w_sel = select_issue(r_pend);
    end
  end

  // A press landing on the issue edge re-arms its bit, so it is never lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend  <= '0;
      r_issue <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_pend  <= (r_pend & ~w_sel) | w_press;
      r_issue <= w_sel;
      r_drop  <= |(w_press & r_pend & ~w_sel);
    end
  end

  assign m100    = r_issue[CH_M100];
  assign dev     = r_issue[CH_DEV];
  assign r_green = r_issue[CH_GREEN];
  assign r_atum  = r_issue[CH_ATUM];
  assign r_bacon = r_issue[CH_BACON];
  assign drop    = r_drop;
  assign pend    = r_pend;

endmodule

// File: doc/sanduba_panel.md
# sanduba_panel

Front-panel input conditioner that sits directly upstream of the sandwich vending machine controller. It synchronizes and debounces the five raw user inputs (coin sensor, refund button, three sandwich buttons) and turns each press into a one-cycle pulse on the controller's `m100`, `dev`, `r_green`, `r_atum` or `r_bacon` inputs. It holds each press pending while the controller reports `busy`, so the controller never sees input while it is busy and no press is lost.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronized cycles needed to accept a level change; legal range 2..255.
- `CW`, default `$clog2(DEB_CYCLES)`: debounce counter width; derived, never overridden.

- `clock`  in  1  single clock; all state on posedge.
- `reset`  in  1  asynchronous, active-low; asserting clears all state immediately, deassertion is synchronous to `clock`.
- `raw_m100`, `raw_dev`, `raw_green`, `raw_atum`, `raw_bacon`  in  1 each  asynchronous, bouncy, active-high.
- `busy`  in  1  from the controller; no pulse is issued while it is high.
- `m100`, `dev`, `r_green`, `r_atum`, `r_bacon`  out  1 each  registered one-cycle pulses to the controller.
- `drop`  out  1  registered one-cycle pulse when a press arrives on a channel that is already pending.
- `pend`  out  5  pending vector, bits {bacon, atum, green, dev, m100} = [4:0], for status and debug.

## Operation
- Per channel:
  - 2-flop synchronizer, then the debounce stage.
  - Counter clears whenever synchronized == stable. When they differ it increments; on the edge where the count is DEB_CYCLES-1 with the mismatch still present, stable takes the new level and the counter clears.
  - A 0->1 update of stable is a press. Releases are ignored.
- Pending bit:
  - Set on a press.
  - Cleared when its channel is issued.
  - Press and issue on the same edge: the bit stays set, so the new press is kept.
  - Press while the bit is already set (and not being issued): bit stays 1 and `drop` pulses.
- FSM states: IDLE, ISSUE, GUARD.
  - IDLE -> ISSUE when `busy`==0 and `pend`!=0. The edge latches the issue vector and clears those pending bits.
  - ISSUE -> GUARD unconditionally. Outputs equal the issue vector for exactly this cycle.
  - GUARD -> IDLE unconditionally. This gives the controller a cycle to raise `busy` before `busy` is sampled again.
- Issue selection, one class per issue, fixed priority:
  1. `dev` alone.
  2. Otherwise `m100` alone.
  3. Otherwise all pending request bits together. Simultaneous requests reach the controller together so it can reject them in its null state.
- `busy` is sampled only in IDLE. Changes of `busy` during ISSUE or GUARD have no effect.

## Timing
- Reset values: all outputs 0, `pend`=0, state IDLE, synchronizers, counters and stable levels 0.
- Reset mid-operation:
  - An in-flight pulse is cut immediately and pending presses are lost.
  - A button held through reset release is seen as a new press, DEB_CYCLES+2 edges after release.
- Latency (raw high and clean before edge 0, `busy`=0, FSM idle):
  - Pending set at edge DEB_CYCLES+1.
  - Output pulse high in the cycle after edge DEB_CYCLES+2.
  - With the default DEB_CYCLES=4, that is after edge 6.
- Issue rate: pulses are at least 3 cycles apart (ISSUE, GUARD, IDLE).
- Glitch filtering: a raw glitch shorter than DEB_CYCLES synchronized cycles produces no press.
- A press that arrives while `busy`=1 is issued on the first IDLE edge with `busy`=0. The pulse is high in the following cycle.

## Structure
- Shared package `sanduba_pkg`:
  - Enum `panel_state_t` {IDLE, ISSUE, GUARD}.
  - Channel index constants `CH_M100`=0, `CH_DEV`=1, `CH_GREEN`=2, `CH_ATUM`=3, `CH_BACON`=4.
  - Sandwich cost constants, shared with the controller.
- Sub-module `sanduba_debounce`: synchronizer, counter, stable level and press output for one channel, parameterized by DEB_CYCLES. Instantiated five times in `sanduba_panel`. The FSM, pending logic and priority logic stay in the top.

## Test plan
- Clean `raw_m100` held high 20 cycles, `busy`=0, DEB_CYCLES=4 -> single `m100` pulse after edge 6, `drop` never set.
- `raw_green` toggling every cycle for 10 cycles, then low -> no output pulse, `pend` stays 0.
- `busy`=1 while `raw_atum` is pressed, `busy` drops at edge 30 -> `r_atum` pulse after edge 31, none earlier.
- `raw_dev`, `raw_m100` and `raw_bacon` pressed on the same edge -> `dev` pulse, then `m100` pulse 3 cycles later, then `r_bacon` pulse 3 cycles after that.
- `raw_green` and `raw_atum` pressed together -> `r_green` and `r_atum` high in the same single cycle.
- `m100` press pending under `busy`, second clean `m100` press -> `drop` pulse. Then `reset` low for 1 cycle -> `pend`=0, no `m100` pulse after `busy` drops.
